// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: serial line in, received byte and status out.
// master = receiver, slave = line driver / byte consumer.
interface uart_rx_if;
  logic       Rx;
  logic       data_ack;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  // data_valid is a level held until data_ack (a one-cycle pulse) is seen with data_valid high;
  // a good frame completing in the same cycle as data_ack reloads data and keeps data_valid high.
  modport master (
    input  Rx, data_ack,
    output data, data_valid, framing_error, overrun, busy, dbg_state
  );

  modport slave (
    output Rx, data_ack,
    input  data, data_valid, framing_error, overrun, busy, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop line synchroniser, mid-bit sampling and valid/ack byte hold.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point (CLKS_PER_BIT >= 6).
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Decision moves one cycle later so the three votes straddle the original sample point.
  localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic            smp;
  logic            load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s_q};
  end

  assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign smp = rx_s_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = dv_q;
    ov_d    = ov_q;
    fe_d    = 1'b0;
    load    = 1'b0;

    if (bus.data_ack && dv_q) begin
      dv_d = 1'b0;
      ov_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == START_PT) begin
          cnt_d = '0;
          if (!smp) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {smp, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (smp) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must return high before a new start can arm.
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A completing frame overrides a same-cycle ack; the ack only suppresses overrun.
    if (load) begin
      data_d = shift_q;
      dv_d   = 1'b1;
      ov_d   = bus.data_ack ? 1'b0 : (ov_q | dv_q);
    end
  end

  assign bus.data          = data_q;
  assign bus.data_valid    = dv_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun       = ov_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: good frames, false start, framing error,
// overrun, ack in the load cycle, reset mid-frame, and a single-cycle glitch on a data bit.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int LOAD_LAT = 156;
`else
  localparam int LOAD_LAT = 155;
`endif
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd4;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock
  always #5 clk = ~clk;

  int   cyc      = 0;
  int   dv_rise  = 0;
  int   fe_cnt   = 0;
  int   total    = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  logic dv_prev  = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.data_valid && !dv_prev) dv_rise = cyc;
    dv_prev = bus.data_valid;
    if (bus.framing_error) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: start bit, 8 data LSB-first, stop bit; optional one-cycle inversion at glitch
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch);
    logic [9:0] line;
    line = {stop, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      bus.Rx = line[c / CPB] ^ (c == glitch);
      @(negedge clk);
    end
  endtask

  task automatic ack_pulse();
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_byte(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, {24'd0, bus.data}, {24'd0, e});
  endtask

  initial begin
    int start_cyc;
    int fe0;

    reset        = 1'b1;
    bus.Rx       = 1'b1;
    bus.data_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, bus.data}, 32'h00);
    check("rst_dv", {31'd0, bus.data_valid}, 32'd0);
    check("rst_fe", {31'd0, bus.framing_error}, 32'd0);
    check("rst_ov", {31'd0, bus.overrun}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // frame 0xA5 with latency bound
    fe0       = fe_cnt;
    start_cyc = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    expect_byte("a5_data");
    check("a5_dv", {31'd0, bus.data_valid}, 32'd1);
    check("a5_latency", {31'd0, ((dv_rise - start_cyc) >= 150) && ((dv_rise - start_cyc) <= LOAD_LAT)}, 32'd1);
    check("a5_no_fe", fe_cnt - fe0, 32'd0);
    check("a5_ov", {31'd0, bus.overrun}, 32'd0);
    check("a5_idle", {31'd0, bus.busy}, 32'd0);
    ack_pulse();
    check("a5_ack_dv", {31'd0, bus.data_valid}, 32'd0);

    // false start: line low for 5 cycles
    bus.Rx = 1'b0;
    repeat (3) @(negedge clk);
    check("fs_busy_hi", {31'd0, bus.busy}, 32'd1);
    repeat (2) @(negedge clk);
    bus.Rx = 1'b1;
    repeat (20) @(negedge clk);
    check("fs_busy_lo", {31'd0, bus.busy}, 32'd0);
    check("fs_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
    check("fs_dv", {31'd0, bus.data_valid}, 32'd0);

    // framing error then line held low (break), then a good 0x55
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1);
    repeat (100) @(negedge clk);
    check("brk_state", {29'd0, bus.dbg_state}, {29'd0, ST_WAIT});
    bus.Rx = 1'b1;
    repeat (20) @(negedge clk);
    check("fe_pulses", fe_cnt - fe0, 32'd1);
    check("fe_data_kept", {24'd0, bus.data}, 32'hA5);
    check("fe_dv", {31'd0, bus.data_valid}, 32'd0);
    check("fe_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -1);
    expect_byte("x55_data");
    check("x55_dv", {31'd0, bus.data_valid}, 32'd1);
    ack_pulse();

    // back-to-back frames without ack -> overrun
    send_frame(8'h11, 1'b1, -1);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, -1);
    expect_byte("ovr_data");
    check("ovr_dv", {31'd0, bus.data_valid}, 32'd1);
    check("ovr_flag", {31'd0, bus.overrun}, 32'd1);
    ack_pulse();
    check("ovr_ack_dv", {31'd0, bus.data_valid}, 32'd0);
    check("ovr_ack_ov", {31'd0, bus.overrun}, 32'd0);

    // ack in the exact load cycle while an older byte is still pending
    send_frame(8'h66, 1'b1, -1);
    check("pre_dv", {31'd0, bus.data_valid}, 32'd1);
    exp_q.push_back(8'h7E);
    fork
      send_frame(8'h7E, 1'b1, -1);
      begin
        repeat (LOAD_LAT - 1) @(negedge clk);
        bus.data_ack = 1'b1;
        @(negedge clk);
        bus.data_ack = 1'b0;
      end
    join
    expect_byte("ldack_data");
    check("ldack_dv", {31'd0, bus.data_valid}, 32'd1);
    check("ldack_ov", {31'd0, bus.overrun}, 32'd0);
    ack_pulse();

    // reset in the middle of the data bits of 0xFF
    fork
      send_frame(8'hFF, 1'b1, -1);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_data", {24'd0, bus.data}, 32'h00);
        reset = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("mrst_dv", {31'd0, bus.data_valid}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    expect_byte("x81_data");
    check("x81_dv", {31'd0, bus.data_valid}, 32'd1);
    ack_pulse();

    // one-cycle high glitch at the mid sample of bit 3 of 0x00
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h08);
`endif
    send_frame(8'h00, 1'b1, 3 * CPB + CPB + CPB / 2);
    expect_byte("glitch_data");
    check("glitch_dv", {31'd0, bus.data_valid}, 32'd1);
    ack_pulse();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
